// File: rtl/wb_arbiter_pkg.sv
// Shared widths, reset level and internal types for the write-back arbiter slice.
package wb_arbiter_pkg;

  localparam int RegAddrBus = 5;
  localparam int RegBus     = 32;
  localparam int RegNum     = 32;
  localparam logic RstEnable = 1'b0;

  typedef struct packed {
    logic [RegAddrBus-1:0] addr;
    logic [RegBus-1:0]     data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_PIPE,
    SRC_FIFO
  } src_sel_t;

  typedef enum logic {
    ARB_RUN,
    ARB_DRAIN
  } arb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Long-latency result queue: power-of-two depth, registered occupancy count.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  wb_entry_t              din,
  output wb_entry_t              dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline vs. long-latency queue, with
// starvation drain and a busy scoreboard for pending long-latency writes.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_LIM = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p_we,
  input  logic [RegAddrBus-1:0] p_waddr,
  input  logic [RegBus-1:0]     p_wdata,
  input  logic                  l_valid,
  input  logic [RegAddrBus-1:0] l_waddr,
  input  logic [RegBus-1:0]     l_wdata,
  output logic                  l_ready,
  input  logic                  rsv_valid,
  input  logic [RegAddrBus-1:0] rsv_addr,
  input  logic [RegAddrBus-1:0] raddr1,
  input  logic [RegAddrBus-1:0] raddr2,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  stall_req,
  output logic                  we,
  output logic [RegAddrBus-1:0] waddr,
  output logic [RegBus-1:0]     wdata
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SC_W  = $clog2(STARVE_LIM + 1);

  wb_entry_t        head;
  wb_entry_t        l_entry;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] count_after;
  logic             push;
  logic             pop;
  logic             pipe_req;
  src_sel_t         sel;
  arb_state_t       state;
  arb_state_t       state_next;
  logic [SC_W-1:0]  starve;
  logic [SC_W-1:0]  starve_next;
  logic [RegNum-1:0] busy;
  logic [RegNum-1:0] busy_next;

  assign l_entry  = '{addr: l_waddr, data: l_wdata};
  assign l_ready  = ~fifo_full & (rst != RstEnable);
  assign push     = l_valid & l_ready;
  assign pipe_req = p_we & (p_waddr != '0);
  assign pop      = (sel == SRC_FIFO);
  assign stall_req = (state == ARB_DRAIN);
  assign count_after = fifo_count + CNT_W'(push) - CNT_W'(pop);

  wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (l_entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A pipeline request to r0 does not claim the port, so the queue may issue.
  always_comb begin
    sel = SRC_NONE;
    if (pipe_req && state == ARB_RUN) sel = SRC_PIPE;
    else if (!fifo_empty)             sel = SRC_FIFO;
  end

  always_comb begin
    starve_next = starve;
    if (fifo_empty || pop)                   starve_next = '0;
    else if (starve != SC_W'(STARVE_LIM))    starve_next = starve + SC_W'(1);
  end

  // Drain holds until the queue is empty, not merely until the counter clears.
  always_comb begin
    state_next = state;
    case (state)
      ARB_RUN:   if (starve_next == SC_W'(STARVE_LIM)) state_next = ARB_DRAIN;
      ARB_DRAIN: if (count_after == '0)                state_next = ARB_RUN;
      default:   state_next = ARB_RUN;
    endcase
  end

  always_comb begin
    busy_next = busy;
    if (pop) busy_next[head.addr] = 1'b0;
    if (rsv_valid && rsv_addr != '0) busy_next[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      state  <= ARB_RUN;
      starve <= '0;
      busy   <= '0;
      we     <= 1'b0;
      waddr  <= '0;
      wdata  <= '0;
    end else begin
      state  <= state_next;
      starve <= starve_next;
      busy   <= busy_next;
      if (sel == SRC_PIPE) begin
        we    <= 1'b1;
        waddr <= p_waddr;
        wdata <= p_wdata;
      end else if (sel == SRC_FIFO && head.addr != '0) begin
        we    <= 1'b1;
        waddr <= head.addr;
        wdata <= head.data;
      end else begin
        we <= 1'b0;
      end
    end
  end

  assign busy1 = (raddr1 != '0) & busy[raddr1];
  assign busy2 = (raddr2 != '0) & busy[raddr2];

endmodule
